// File: rtl/seg_pkg.sv
// Shared definitions for the sequential seven-segment display driver:
// active-low segment codes (a..g, a in the MSB), FSM states and BCD sizing.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    // Decimal digits needed for any width-bit value: floor(width*log10(2))+1.
    function automatic int bcd_digits(input int width);
        return (width * 32'sd30103) / 32'sd100000 + 32'sd1;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low seven-segment decoder (a..g, a in MSB).
// Codes 10-15 are not decimal digits and render blank.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Digit code lookup
    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_disp_seq.sv
// Multi-digit decimal display driver: sequential double-dabble binary-to-BCD
// conversion, then registered seven-segment outputs with blanking and overflow.
module seg_disp_seq
    import seg_pkg::*;
#(
    parameter int WIDTH  = 7,
    parameter int DIGITS = 3
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int NB = bcd_digits(WIDTH);
    localparam int NP = (NB > DIGITS) ? NB : DIGITS;
    localparam int PW = 4 * NP;
    localparam int CW = $clog2(WIDTH + 1);

    state_e                state_q, state_d;
    logic [4*NB-1:0]       bcd_q, bcd_d;
    logic [WIDTH-1:0]      shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  blank_q, blank_d;
    logic [7*DIGITS-1:0]   hex_q, hex_d;
    logic                  ovf_q, ovf_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    // Digits above the BCD register read as zero.
    logic [PW-1:0]         bcd_pad_s;
    logic [6:0]            seg_s [DIGITS];
    logic [7*DIGITS-1:0]   disp_s;
    logic                  ovf_s;

    assign bcd_pad_s = PW'(bcd_q);

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        bcd_to_seg u_dec (
            .bcd (bcd_pad_s[4*g +: 4]),
            .seg (seg_s[g])
        );
    end

    // Render the finished BCD value: overflow dashes, leading-zero blanking
    always_comb begin
        logic       seen;
        logic [6:0] s;
        ovf_s  = 1'b0;
        seen   = 1'b0;
        s      = SEG_BLANK;
        disp_s = '1;
        for (int i = DIGITS; i < NP; i++) begin
            ovf_s = ovf_s | (bcd_pad_s[4*i +: 4] != 4'd0);
        end
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen = seen | (bcd_pad_s[4*i +: 4] != 4'd0);
            if (ovf_s) begin
                s = SEG_DASH;
            end else if (blank_q && !seen && (i != 0)) begin
                s = SEG_BLANK;
            end else begin
                s = seg_s[i];
            end
            // Segment a (pattern MSB) lands on the lowest bit of each digit.
            for (int k = 0; k < 7; k++) begin
                disp_s[7*i + k] = s[6 - k];
            end
        end
    end

    // Next-state and datapath control
    always_comb begin
        logic [4*NB-1:0] adj;
        state_d = state_q;
        bcd_d   = bcd_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        blank_d = blank_q;
        hex_d   = hex_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        adj     = bcd_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = value;
                    blank_d = blank_lz;
                    bcd_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                for (int j = 0; j < NB; j++) begin
                    if (bcd_q[4*j +: 4] >= 4'd5) begin
                        adj[4*j +: 4] = bcd_q[4*j +: 4] + 4'd3;
                    end else begin
                        adj[4*j +: 4] = bcd_q[4*j +: 4];
                    end
                end
                bcd_d   = {adj[4*NB-2:0], shift_q[WIDTH-1]};
                shift_d = shift_q << 1'b1;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end else begin
                    state_d = CONV;
                end
            end
            DONE: begin
                hex_d   = disp_s;
                ovf_d   = ovf_s;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // busy stays up through the cycle that shows done
        busy_d = (state_d != IDLE) || done_d;
    end

    // State and output registers
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            blank_q <= 1'b0;
            hex_q   <= '1;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            blank_q <= blank_d;
            hex_q   <= hex_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;
    assign hex  = hex_q;

endmodule

// File: tb/tb_seg_disp_seq.sv
// Scoreboard bench for seg_disp_seq: three configurations (7/3, 10/3, 4/4)
// driven with directed and random requests against a decimal reference model.
module tb_seg_disp_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        blank = 1'b0;
    logic [2:0]  st = 3'b000;
    logic [9:0]  val = 10'd0;

    logic        b0, d0, o0, b1, d1, o1, b2, d2, o2;
    logic [20:0] h0, h1;
    logic [27:0] h2;

    always #10 clk = ~clk;

    seg_disp_seq #(.WIDTH(7), .DIGITS(3)) u0 (
        .CLOCK_50(clk), .reset(reset), .start(st[0]), .value(val[6:0]),
        .blank_lz(blank), .busy(b0), .done(d0), .ovf(o0), .hex(h0));
    seg_disp_seq #(.WIDTH(10), .DIGITS(3)) u1 (
        .CLOCK_50(clk), .reset(reset), .start(st[1]), .value(val[9:0]),
        .blank_lz(blank), .busy(b1), .done(d1), .ovf(o1), .hex(h1));
    seg_disp_seq #(.WIDTH(4), .DIGITS(4)) u2 (
        .CLOCK_50(clk), .reset(reset), .start(st[2]), .value(val[3:0]),
        .blank_lz(blank), .busy(b2), .done(d2), .ovf(o2), .hex(h2));

    typedef struct {
        int          k;
        int          acc;
        int          due;
        logic [27:0] hx;
        logic        ov;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    bit          rst_edge = 1'b0;
    bit          armed = 1'b0;
    logic [27:0] cur_hex [3];
    logic        cur_ov [3];

    function automatic int wid(input int k);
        case (k)
            0: return 7;
            1: return 10;
            default: return 4;
        endcase
    endfunction

    function automatic int dig(input int k);
        case (k)
            0: return 3;
            1: return 3;
            default: return 4;
        endcase
    endfunction

    // Segment pattern as written a..g (a is the leftmost character).
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            default: return 7'b0000100;
        endcase
    endfunction

    function automatic logic [27:0] ones(input int d);
        logic [27:0] r;
        r = 28'd0;
        for (int i = 0; i < 7 * d; i++) r[i] = 1'b1;
        return r;
    endfunction

    // Reference: {ovf, hex} computed from decimal arithmetic on the value.
    function automatic logic [28:0] model(input int v, input bit b, input int d);
        logic [27:0] h;
        logic [6:0]  s;
        logic        ov;
        int          p;
        h  = 28'd0;
        ov = (v >= 10 ** d);
        p  = 1;
        for (int i = 0; i < d; i++) begin
            if (ov) s = 7'b1111110;
            else if (b && i > 0 && v < p) s = 7'b1111111;
            else s = seg_of((v / p) % 10);
            for (int k = 0; k < 7; k++) h[7*i + k] = s[6 - k];
            p = p * 10;
        end
        return {ov, h};
    endfunction

    task automatic chk(input string nm, input int k, input logic [27:0] act, input logic [27:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s u%0d cyc %0d: got %h expected %h", nm, k, cyc, act, exp);
        end
    endtask

    task automatic mon(input int k, input logic dn, input logic bs, input logic [27:0] hx, input logic ov);
        logic ed, eb;
        ed = (q.size() > 0) && (q[0].k == k) && (q[0].due == cyc);
        eb = (q.size() > 0) && (q[0].k == k) && (q[0].acc <= cyc);
        if (ed) begin
            cur_hex[k] = q[0].hx;
            cur_ov[k]  = q[0].ov;
            void'(q.pop_front());
        end
        chk("done", k, 28'(dn), 28'(ed));
        chk("busy", k, 28'(bs), 28'(eb));
        chk("hex",  k, hx, cur_hex[k]);
        chk("ovf",  k, 28'(ov), 28'(cur_ov[k]));
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= reset;
    end

    // Monitor: compares every instance each cycle against the scoreboard
    always @(negedge clk) begin
        if (rst_edge) begin
            q.delete();
            for (int k = 0; k < 3; k++) begin
                cur_hex[k] = ones(dig(k));
                cur_ov[k]  = 1'b0;
            end
            armed = 1'b1;
        end
        if (armed) begin
            mon(0, d0, b0, 28'(h0), o0);
            mon(1, d1, b1, 28'(h1), o1);
            mon(2, d2, b2, h2, o2);
        end
    end

    task automatic go(input int k, input int v, input bit b, output int acc);
        exp_t        e;
        logic [28:0] m;
        @(negedge clk);
        st    = 3'b000;
        st[k] = 1'b1;
        val   = 10'(v);
        blank = b;
        m     = model(v, b, dig(k));
        e.k   = k;
        e.acc = cyc + 1;
        e.due = cyc + 1 + wid(k) + 1;
        e.hx  = m[27:0];
        e.ov  = m[28];
        q.push_back(e);
        acc = e.acc;
        @(negedge clk);
        st = 3'b000;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Start requests while busy; these must be ignored.
    task automatic pulse(input int k, input int n, input int v);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            st[k] = 1'b1;
            val   = (v < 0) ? 10'($urandom) : 10'(v);
            blank = 1'($urandom);
        end
        @(negedge clk);
        st = 3'b000;
    endtask

    task automatic run(input int k, input int v, input bit b, input int gap);
        int a;
        go(k, v, b, a);
        wait_until(a + wid(k) + gap);
    endtask

    initial begin
        int a;
        int v;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        run(0, 127, 1'b0, 1);
        run(0, 5, 1'b1, 1);
        run(0, 0, 1'b1, 1);
        run(0, 105, 1'b1, 1);

        go(0, 127, 1'b0, a);
        pulse(0, 4, 3);
        wait_until(a + 7);
        go(0, 3, 1'b0, a);
        wait_until(a + 9);

        go(0, 99, 1'b0, a);
        wait_until(a + 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run(0, 77, 1'b1, 1);

        run(1, 999, 1'b0, 1);
        run(1, 1000, 1'b0, 1);
        run(1, 42, 1'b0, 1);
        run(1, 1023, 1'b1, 1);

        run(2, 15, 1'b0, 1);
        run(2, 0, 1'b0, 1);
        run(2, 7, 1'b1, 1);

        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 25; n++) begin
                v = int'($urandom_range(0, (1 << wid(k)) - 1));
                go(k, v, 1'($urandom), a);
                pulse(k, int'($urandom_range(0, wid(k) - 1)), -1);
                wait_until(a + wid(k) + int'($urandom_range(0, 3)));
            end
        end

        wait_until(cyc + 15);
        chk("drain", 3, 28'(q.size()), 28'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_disp_seq.md
Name: seg_disp_seq

Overview:
Parametrised multi-digit decimal display driver for the board's seven-segment HEX displays. It converts an unsigned binary value to BCD sequentially, one shift-and-adjust (double-dabble) step per clock. It then drives DIGITS active-low seven-segment outputs, with optional leading-zero blanking and overflow indication. Successor to the fixed 7-bit, three-digit switch display; top-level wrappers tie unused HEX outputs high.

Parameters:
WIDTH, 7, bit width of the binary input value (>=1)
DIGITS, 3, number of seven-segment digits driven (>=1)

Ports:
CLOCK_50  in  1  system clock; all state changes on its rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request a conversion of value; sampled only in IDLE
value  in  WIDTH  unsigned binary value to display
blank_lz  in  1  1 = blank leading zeros; sampled with start
busy  out  1  high while a conversion is in progress (CONV or DONE)
done  out  1  one-cycle pulse when hex/ovf are updated
ovf  out  1  value needs more than DIGITS decimal digits; held until next done
hex  out  7*DIGITS  segments, active low; digit i at hex[7i+0..7i+6] = segments a..g; digit 0 least significant

Behaviour:
- Reset: state IDLE, busy=0, done=0, ovf=0, every hex bit 1 (all segments off). Reset wins over every other input, including in CONV.
- Internal BCD register has NB = floor(WIDTH*0.30103)+1 digits, enough for any WIDTH-bit value. It is 4*NB bits wide, plus a WIDTH-bit shift register and a step counter.
- FSM:
  - IDLE: start=1 captures value and blank_lz, clears BCD, loads counter=WIDTH, goes to CONV. start=0 holds state.
  - CONV: each cycle, add 3 to every BCD digit >=5, then shift {bcd,shift} left by 1. Decrement counter; after the WIDTH-th step go to DONE.
  - DONE: register hex and ovf from the BCD result, pulse done=1, go to IDLE.
- start in CONV or DONE is ignored. No queuing.
- Latency: start sampled at edge k produces done=1 and new hex/ovf after edge k+WIDTH+1. busy=1 from edge k+1 through the done cycle. The earliest next start is accepted at edge k+WIDTH+2.
- Outputs hold their last values between conversions. value changes after capture have no effect.
- Overflow:
  - Raised if any BCD digit with index >= DIGITS is nonzero, or equivalently value > 10^DIGITS-1.
  - On overflow, all DIGITS show dash (segment g only: 1111110 in a..g order) and ovf=1.
  - Otherwise ovf=0.
- If DIGITS > NB, digits >= NB are treated as 0: blanked when blank_lz=1, shown as "0" otherwise.
- Leading-zero blanking (blank_lz=1):
  - Zero digits above the most significant nonzero digit are blank (1111111).
  - Digit 0 is always shown, so value 0 displays "0".
  - Internal zeros (e.g. 105) are shown.
- Segment encoding, a..g, active low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
- Arithmetic is unsigned only; no negative display.

Decomposition:
- Shared package seg_pkg holds:
  - the segment constants SEG_0..SEG_9, SEG_BLANK=7'b1111111 and SEG_DASH=7'b1111110;
  - the state enum {IDLE, CONV, DONE};
  - a function bcd_digits(width) returning NB.
- One natural sub-module: bcd_to_seg, a combinational 4-bit BCD to 7-bit active-low decoder, instanced per digit. It returns SEG_BLANK for codes 10-15.

Test Plan:
- Defaults; reset held 3 cycles -> hex all 1, busy=0, done=0, ovf=0. Then start with value=127, blank_lz=0 -> done exactly 8 cycles after start. Expected hex digit2=1001111, digit1=0010010, digit0=0001111, ovf=0.
- value=5, blank_lz=1 -> digit2 and digit1 = 1111111, digit0=0100100. Then value=0, blank_lz=1 -> digit0=0000001, others blank. Then value=105, blank_lz=1 -> digits 1,0,5 with internal zero shown.
- WIDTH=10, DIGITS=3: value=999 -> all three digits 0000100, ovf=0. value=1000 -> all digits 1111110, ovf=1. Next conversion of 42 -> ovf returns to 0.
- Start with value=127, then start with value=3 pulsed on cycles 2-5 while busy -> second request ignored, result shows 127. Start in IDLE immediately after done -> accepted, 3 displayed WIDTH+1 cycles later.
- Reset asserted mid-CONV (cycle 4 of 7) -> next edge: IDLE, busy=0, hex all 1. A fresh start then converts correctly.
- WIDTH=4, DIGITS=4, value=15, blank_lz=0 -> digits 3..0 = 0,0,1,5 (0000001, 0000001, 1001111, 0100100). Digit 3 lies above NB and shows "0".
